// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the CPU load/store port and
// the loader/debug port. Round-robin grant, address window check, byte to
// word translation and registered DMEM strobes; each port gets a req/ack
// handshake with an error flag and captured read data.
module dmem_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h10010000,
  parameter int          DEPTH     = 1024,
  parameter int          AW        = 10
) (
  input  logic          clk_in,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic          cpu_ack,
  output logic          cpu_err,
  output logic [31:0]   cpu_rdata,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [31:0]   ld_addr,
  input  logic [31:0]   ld_wdata,
  output logic          ld_ack,
  output logic          ld_err,
  output logic [31:0]   ld_rdata,
  output logic          dm_cs,
  output logic          dm_w,
  output logic          dm_r,
  output logic [AW-1:0] dm_addr,
  output logic [31:0]   dm_wdata,
  input  logic [31:0]   dm_rdata
);

  // Window bounds held in 33 bits so the upper bound cannot wrap.
  localparam logic [32:0]   WIN_LO    = {1'b0, BASE_ADDR};
  localparam logic [32:0]   WIN_HI    = WIN_LO + (33'(DEPTH) << 2) - 33'd1;
  localparam logic [AW-1:0] BASE_WORD = BASE_ADDR[AW+1:2];
  localparam logic          GNT_CPU   = 1'b0;
  localparam logic          GNT_LD    = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t        state_r;
  logic          last_gnt_r;
  logic          gnt_r;
  logic          we_r;

  logic          req_any_s;
  logic          pick_ld_s;
  logic          sel_we_s;
  logic [31:0]   sel_addr_s;
  logic [31:0]   sel_wdata_s;
  logic          legal_s;
  logic [AW-1:0] word_s;

  // Word aligned and inside [BASE_ADDR, BASE_ADDR + 4*DEPTH - 1].
  function automatic logic in_window(input logic [31:0] a);
    logic [32:0] ax;
    ax = {1'b0, a};
    return (a[1:0] == 2'b00) && (ax >= WIN_LO) && (ax <= WIN_HI);
  endfunction

  // Round-robin pick and mux of the candidate request fields.
  always_comb begin
    req_any_s = cpu_req | ld_req;
    pick_ld_s = 1'b0;
    if (cpu_req && ld_req) begin
      pick_ld_s = (last_gnt_r == GNT_CPU);
    end else if (ld_req) begin
      pick_ld_s = 1'b1;
    end else begin
      pick_ld_s = 1'b0;
    end
    if (pick_ld_s) begin
      sel_we_s    = ld_we;
      sel_addr_s  = ld_addr;
      sel_wdata_s = ld_wdata;
    end else begin
      sel_we_s    = cpu_we;
      sel_addr_s  = cpu_addr;
      sel_wdata_s = cpu_wdata;
    end
    legal_s = in_window(sel_addr_s);
    // Both operands are word aligned, so no borrow crosses bit 2.
    word_s  = sel_addr_s[AW+1:2] - BASE_WORD;
  end

  // Arbiter FSM; every port output is a register updated here.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_r    <= S_IDLE;
      last_gnt_r <= GNT_LD;
      gnt_r      <= GNT_CPU;
      we_r       <= 1'b0;
      cpu_ack    <= 1'b0;
      cpu_err    <= 1'b0;
      cpu_rdata  <= 32'd0;
      ld_ack     <= 1'b0;
      ld_err     <= 1'b0;
      ld_rdata   <= 32'd0;
      dm_cs      <= 1'b0;
      dm_w       <= 1'b0;
      dm_r       <= 1'b0;
      dm_addr    <= {AW{1'b0}};
      dm_wdata   <= 32'd0;
    end else begin
      cpu_ack  <= 1'b0;
      cpu_err  <= 1'b0;
      ld_ack   <= 1'b0;
      ld_err   <= 1'b0;
      dm_cs    <= 1'b0;
      dm_w     <= 1'b0;
      dm_r     <= 1'b0;
      dm_addr  <= {AW{1'b0}};
      dm_wdata <= 32'd0;
      case (state_r)
        S_ACCESS: begin
          state_r <= S_DONE;
          if (gnt_r == GNT_LD) begin
            ld_ack <= 1'b1;
            if (!we_r) begin
              ld_rdata <= dm_rdata;
            end
          end else begin
            cpu_ack <= 1'b1;
            if (!we_r) begin
              cpu_rdata <= dm_rdata;
            end
          end
        end
        S_IDLE, S_DONE: begin
          if (req_any_s) begin
            gnt_r      <= pick_ld_s;
            last_gnt_r <= pick_ld_s;
            we_r       <= sel_we_s;
            if (legal_s) begin
              state_r  <= S_ACCESS;
              dm_cs    <= 1'b1;
              dm_w     <= sel_we_s;
              dm_r     <= ~sel_we_s;
              dm_addr  <= word_s;
              dm_wdata <= sel_wdata_s;
            end else begin
              // Rejected: skip the memory and complete next cycle.
              state_r <= S_DONE;
              if (pick_ld_s) begin
                ld_ack   <= 1'b1;
                ld_err   <= 1'b1;
                ld_rdata <= 32'd0;
              end else begin
                cpu_ack   <= 1'b1;
                cpu_err   <= 1'b1;
                cpu_rdata <= 32'd0;
              end
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
